// File: rtl/alu_writeback_stage_pkg.sv
// Shared types and helpers for the ALU writeback stage: op encoding, the
// {Z,C,V,N} flag layout, per-op flag masks and the register-write predicate.
package alu_writeback_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'h0,
        ALU_ADC     = 4'h1,
        ALU_SUB     = 4'h2,
        ALU_SBC     = 4'h3,
        ALU_CMP     = 4'h4,
        ALU_AND     = 4'h5,
        ALU_ORR     = 4'h6,
        ALU_XOR     = 4'h7,
        ALU_LSL     = 4'h8,
        ALU_LSR     = 4'h9,
        ALU_ASR     = 4'hA,
        ALU_ROL     = 4'hB,
        ALU_ROR     = 4'hC,
        ALU_ROLC    = 4'hD,
        ALU_RORC    = 4'hE,
        ALU_ILLEGAL = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic n;
    } alu_flags_t;

    localparam int unsigned ALU_FLAG_Z = 32'd3;
    localparam int unsigned ALU_FLAG_C = 32'd2;
    localparam int unsigned ALU_FLAG_V = 32'd1;
    localparam int unsigned ALU_FLAG_N = 32'd0;

    localparam logic [1:0] WB_FIFO_FULL = 2'd2;

    // Which of {Z,C,V,N} an op is allowed to update at retire.
    function automatic logic [3:0] alu_op_flag_mask(input logic [3:0] op);
        logic [3:0] mask;
        case (op)
            ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_CMP: mask = 4'b1111;
            ALU_AND, ALU_ORR, ALU_XOR:                   mask = 4'b1001;
            ALU_LSL, ALU_LSR, ALU_ASR, ALU_ROL,
            ALU_ROR, ALU_ROLC, ALU_RORC:                 mask = 4'b1101;
            ALU_ILLEGAL:                                 mask = 4'b0000;
            default:                                     mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Compare and illegal ops produce no register-file write.
    function automatic logic alu_op_writes_rd(input logic [3:0] op);
        logic wr;
        case (op)
            ALU_CMP, ALU_ILLEGAL: wr = 1'b0;
            default:              wr = 1'b1;
        endcase
        return wr;
    endfunction

    // Replace only the masked flag bits with the raw ALU flags.
    function automatic alu_flags_t alu_flags_merge(input alu_flags_t cur,
                                                   input alu_flags_t raw,
                                                   input logic [3:0] mask);
        alu_flags_t res;
        res = (cur & ~mask) | (raw & mask);
        return res;
    endfunction

endpackage

// File: rtl/alu_wb_skid_buf.sv
// Two-entry in-order buffer of ALU results {op,result,flags,rd_idx}.
// Entry 0 is always the head; a pop shifts entry 1 down. Also reports, per
// valid entry, whether it targets a queried register and whether it will
// touch the flags register.
module alu_wb_skid_buf
    import alu_writeback_stage_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  logic [3:0]           push_op,
    input  logic [DATA_W-1:0]    push_result,
    input  logic [3:0]           push_flags,
    input  logic [REG_IDX_W-1:0] push_rd_idx,
    input  logic [REG_IDX_W-1:0] cmp_idx,
    output logic [1:0]           count,
    output logic                 head_valid,
    output logic [3:0]           head_op,
    output logic [DATA_W-1:0]    head_result,
    output logic [3:0]           head_flags,
    output logic [REG_IDX_W-1:0] head_rd_idx,
    output logic [1:0]           rd_hit,
    output logic [1:0]           flag_use
);

    logic [1:0]                count_r;
    logic [1:0]                count_nxt_s;
    logic [1:0][3:0]           op_r;
    logic [1:0][3:0]           op_nxt_s;
    logic [1:0][DATA_W-1:0]    result_r;
    logic [1:0][DATA_W-1:0]    result_nxt_s;
    logic [1:0][3:0]           flags_r;
    logic [1:0][3:0]           flags_nxt_s;
    logic [1:0][REG_IDX_W-1:0] rd_r;
    logic [1:0][REG_IDX_W-1:0] rd_nxt_s;
    logic [1:0]                valid_s;
    logic                      push_ok_s;
    logic                      pop_ok_s;

    // Never accept into a full buffer and never pop an empty one.
    assign push_ok_s = push && (count_r != WB_FIFO_FULL);
    assign pop_ok_s  = pop && (count_r != 2'd0);

    assign valid_s[0] = (count_r != 2'd0);
    assign valid_s[1] = (count_r == WB_FIFO_FULL);

    // Next state: flush empties; pop shifts down; push lands behind survivors.
    always_comb begin
        count_nxt_s  = count_r;
        op_nxt_s     = op_r;
        result_nxt_s = result_r;
        flags_nxt_s  = flags_r;
        rd_nxt_s     = rd_r;
        if (flush) begin
            count_nxt_s = 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    op_nxt_s[count_r[0]]     = push_op;
                    result_nxt_s[count_r[0]] = push_result;
                    flags_nxt_s[count_r[0]]  = push_flags;
                    rd_nxt_s[count_r[0]]     = push_rd_idx;
                    count_nxt_s              = count_r + 2'd1;
                end
                2'b01: begin
                    op_nxt_s[0]     = op_r[1];
                    result_nxt_s[0] = result_r[1];
                    flags_nxt_s[0]  = flags_r[1];
                    rd_nxt_s[0]     = rd_r[1];
                    count_nxt_s     = count_r - 2'd1;
                end
                2'b11: begin
                    // Only reachable at count 1: the new entry becomes head.
                    op_nxt_s[0]     = push_op;
                    result_nxt_s[0] = push_result;
                    flags_nxt_s[0]  = push_flags;
                    rd_nxt_s[0]     = push_rd_idx;
                    count_nxt_s     = count_r;
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
    end

    // Buffer storage; async reset clears occupancy and contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= 2'd0;
            op_r     <= '0;
            result_r <= '0;
            flags_r  <= '0;
            rd_r     <= '0;
        end else begin
            count_r  <= count_nxt_s;
            op_r     <= op_nxt_s;
            result_r <= result_nxt_s;
            flags_r  <= flags_nxt_s;
            rd_r     <= rd_nxt_s;
        end
    end

    // Per-entry hazard match and pending-flag indication from stored state only.
    always_comb begin
        rd_hit   = 2'b00;
        flag_use = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rd_hit[i]   = valid_s[i] && alu_op_writes_rd(op_r[i]) && (rd_r[i] == cmp_idx);
            flag_use[i] = valid_s[i] && (alu_op_flag_mask(op_r[i]) != 4'b0000);
        end
    end

    assign count       = count_r;
    assign head_valid  = valid_s[0];
    assign head_op     = op_r[0];
    assign head_result = result_r[0];
    assign head_flags  = flags_r[0];
    assign head_rd_idx = rd_r[0];

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: buffers up to two ALU results in order, writes the
// register file at retire and merges the raw ALU flags into the committed
// {Z,C,V,N} register under a per-op mask. Provides flags-pending and a
// destination-hazard lookup to issue.
// Optional feature macro: ALU_WB_BYPASS_EN -- when the buffer is empty, a
// register-writing result is presented on wb_* in the same cycle and retires
// immediately if the register file accepts it.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int REG_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [DATA_W-1:0]    in_result,
    input  logic [3:0]           in_flags,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [REG_IDX_W-1:0] wb_idx,
    output logic [DATA_W-1:0]    wb_data,
    output logic [3:0]           flags_q,
    output logic                 flags_pend,
    input  logic [REG_IDX_W-1:0] hz_idx,
    output logic                 hz_hit
);

    logic [1:0]           count_s;
    logic                 head_valid_s;
    logic [3:0]           head_op_s;
    logic [DATA_W-1:0]    head_result_s;
    logic [3:0]           head_flags_s;
    logic [REG_IDX_W-1:0] head_rd_idx_s;
    logic [1:0]           rd_hit_s;
    logic [1:0]           flag_use_s;
    logic                 head_writes_s;
    logic                 head_retire_s;
    logic                 byp_s;
    logic                 byp_take_s;
    logic                 push_s;
    alu_flags_t           flags_r;
    alu_flags_t           flags_nxt_s;

    assign in_ready = (count_s != WB_FIFO_FULL);

`ifdef ALU_WB_BYPASS_EN
    // Empty buffer and a register-writing result: present it straight away.
    assign byp_s = (count_s == 2'd0) && in_valid && !flush && alu_op_writes_rd(in_op);
`else
    assign byp_s = 1'b0;
`endif

    assign byp_take_s    = byp_s && wb_ready;
    assign push_s        = in_valid && in_ready && !flush && !byp_take_s;
    assign head_writes_s = head_valid_s && alu_op_writes_rd(head_op_s);
    // cmp/illegal retire in their first head cycle; others need the write accepted.
    assign head_retire_s = !flush && head_valid_s &&
                           (!alu_op_writes_rd(head_op_s) || wb_ready);

    alu_wb_skid_buf #(
        .DATA_W    (DATA_W),
        .REG_IDX_W (REG_IDX_W)
    ) u_skid_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .push        (push_s),
        .pop         (head_retire_s),
        .push_op     (in_op),
        .push_result (in_result),
        .push_flags  (in_flags),
        .push_rd_idx (in_rd_idx),
        .cmp_idx     (hz_idx),
        .count       (count_s),
        .head_valid  (head_valid_s),
        .head_op     (head_op_s),
        .head_result (head_result_s),
        .head_flags  (head_flags_s),
        .head_rd_idx (head_rd_idx_s),
        .rd_hit      (rd_hit_s),
        .flag_use    (flag_use_s)
    );

    // Register-file write request; a flush withholds it so no uncounted write escapes.
    always_comb begin
        wb_valid = 1'b0;
        wb_idx   = head_rd_idx_s;
        wb_data  = head_result_s;
        if (flush) begin
            wb_valid = 1'b0;
        end else if (byp_s) begin
            wb_valid = 1'b1;
            wb_idx   = in_rd_idx;
            wb_data  = in_result;
        end else begin
            wb_valid = head_writes_s;
        end
    end

    // Flag merge for whichever entry retires this cycle (head or bypassed input).
    always_comb begin
        flags_nxt_s = flags_r;
        if (head_retire_s) begin
            flags_nxt_s = alu_flags_merge(flags_r, alu_flags_t'(head_flags_s),
                                          alu_op_flag_mask(head_op_s));
        end else if (byp_take_s) begin
            flags_nxt_s = alu_flags_merge(flags_r, alu_flags_t'(in_flags),
                                          alu_op_flag_mask(in_op));
        end else begin
            flags_nxt_s = flags_r;
        end
    end

    // Committed processor flags; flush leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= '0;
        end else begin
            flags_r <= flags_nxt_s;
        end
    end

    assign flags_q    = flags_r;
    assign flags_pend = |flag_use_s;
    assign hz_hit     = |rd_hit_s;

endmodule

// File: tb/tb_alu_writeback_stage.sv
`timescale 1ns/1ps
module tb_alu_writeback_stage;

    localparam int DATA_W    = 8;
    localparam int REG_IDX_W = 4;
    localparam int OP_ADD = 0, OP_SUB = 2, OP_CMP = 4, OP_AND = 5,
                   OP_XOR = 7, OP_LSL = 8, OP_ILL = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [3:0] in_op = 4'h0;
    logic [DATA_W-1:0] in_result = 8'h00;
    logic [3:0] in_flags = 4'h0;
    logic [REG_IDX_W-1:0] in_rd_idx = 4'h0;
    logic wb_valid;
    logic wb_ready = 1'b0;
    logic [REG_IDX_W-1:0] wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic [3:0] flags_q;
    logic flags_pend;
    logic [REG_IDX_W-1:0] hz_idx = 4'h0;
    logic hz_hit;

    alu_writeback_stage #(.DATA_W(DATA_W), .REG_IDX_W(REG_IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_result(in_result), .in_flags(in_flags), .in_rd_idx(in_rd_idx),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_data(wb_data),
        .flags_q(flags_q), .flags_pend(flags_pend), .hz_idx(hz_idx), .hz_hit(hz_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       writes;
        logic [3:0] idx;
        logic [7:0] data;
        logic [3:0] mask;
        logic [3:0] flags_after;
        int         push_cyc;
        logic       byp;
    } exp_t;

    exp_t sb[$];
    logic [3:0] committed = 4'h0;   // flags the DUT should hold now
    logic [3:0] run_flags = 4'h0;   // flags after every accepted entry retires
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference flag mask per op class.
    function automatic logic [3:0] ref_mask(input int op);
        if (op == OP_ILL) return 4'b0000;
        if (op <= OP_CMP) return 4'b1111;
        if (op <= OP_XOR) return 4'b1001;
        return 4'b1101;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One stimulus cycle; on acceptance the expected retirement goes into the scoreboard.
    task automatic drive(input logic v, input int op, input logic [7:0] res,
                         input logic [3:0] fl, input logic [3:0] rd,
                         input logic wbr, input logic fsh, input logic [3:0] hz);
        exp_t e;
        logic byp_build;
`ifdef ALU_WB_BYPASS_EN
        byp_build = 1'b1;
`else
        byp_build = 1'b0;
`endif
        @(posedge clk);
        #1;
        in_valid = v; in_op = op[3:0]; in_result = res; in_flags = fl;
        in_rd_idx = rd; wb_ready = wbr; flush = fsh; hz_idx = hz;
        @(negedge clk);
        if (rst_n && !flush && in_valid && sb.size() != 2) begin
            e.writes = (op != OP_CMP) && (op != OP_ILL);
            e.idx = rd;
            e.data = res;
            e.mask = ref_mask(op);
            run_flags = (run_flags & ~e.mask) | (fl & e.mask);
            e.flags_after = run_flags;
            e.push_cyc = cyc;
            e.byp = byp_build && (sb.size() == 0) && e.writes;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic wbr);
        for (int i = 0; i < n; i++) drive(1'b0, OP_ADD, 8'h00, 4'h0, 4'h0, wbr, 1'b0, 4'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_flags_q"}, {28'd0, flags_q}, 32'd0);
        check({tag, "_flags_pend"}, {31'd0, flags_pend}, 32'd0);
        check({tag, "_hz_hit"}, {31'd0, hz_hit}, 32'd0);
    endtask

    // Monitor: compares outputs against the scoreboard each cycle, away from edges.
    initial begin
        int present;
        logic exp_pend, exp_hit;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) continue;
            present = 0; exp_pend = 1'b0; exp_hit = 1'b0;
            foreach (sb[i]) begin
                if (sb[i].push_cyc < cyc) begin
                    present++;
                    if (sb[i].mask != 4'b0000) exp_pend = 1'b1;
                    if (sb[i].writes && sb[i].idx == hz_idx) exp_hit = 1'b1;
                end
            end
            check("in_ready", {31'd0, in_ready}, {31'd0, present != 2});
            check("flags_pend", {31'd0, flags_pend}, {31'd0, exp_pend});
            check("hz_hit", {31'd0, hz_hit}, {31'd0, exp_hit});
            check("flags_q", {28'd0, flags_q}, {28'd0, committed});
            if (flush) begin
                check("wb_valid_flush", {31'd0, wb_valid}, 32'd0);
                sb.delete();
                run_flags = committed;
            end else if (sb.size() > 0 && (sb[0].push_cyc < cyc || sb[0].byp)) begin
                if (!sb[0].writes) begin
                    check("wb_valid_nowrite", {31'd0, wb_valid}, 32'd0);
                    committed = sb[0].flags_after;
                    void'(sb.pop_front());
                end else begin
                    check("wb_valid_head", {31'd0, wb_valid}, 32'd1);
                    if (wb_ready) begin
                        check("wb_idx", {28'd0, wb_idx}, {28'd0, sb[0].idx});
                        check("wb_data", {24'd0, wb_data}, {24'd0, sb[0].data});
                        committed = sb[0].flags_after;
                        void'(sb.pop_front());
                    end
                end
            end else begin
                check("wb_valid_idle", {31'd0, wb_valid}, 32'd0);
            end
        end
    end

    initial begin
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #1; rst_n = 1'b1;

        // Basic add: visible the cycle after the push, flags 1000 committed.
        drive(1'b1, OP_ADD, 8'h00, 4'b1000, 4'd3, 1'b1, 1'b0, 4'd0);
        idle(3, 1'b1);
        check("t1_flags", {28'd0, flags_q}, 32'h8);

        // Masked merge: and keeps C/V, cmp overwrites everything without a write.
        drive(1'b1, OP_ADD, 8'h11, 4'b0100, 4'd2, 1'b1, 1'b0, 4'd0);
        idle(2, 1'b1);
        check("t2_flags_a", {28'd0, flags_q}, 32'h4);
        drive(1'b1, OP_AND, 8'h22, 4'b1000, 4'd1, 1'b1, 1'b0, 4'd0);
        idle(2, 1'b1);
        check("t2_flags_b", {28'd0, flags_q}, 32'hC);
        drive(1'b1, OP_CMP, 8'h33, 4'b0011, 4'd1, 1'b1, 1'b0, 4'd0);
        idle(2, 1'b1);
        check("t2_flags_c", {28'd0, flags_q}, 32'h3);

        // Back-pressure: two fill the buffer, the third is refused.
        drive(1'b1, OP_ADD, 8'hA1, 4'b0001, 4'd5, 1'b0, 1'b0, 4'd5);
        drive(1'b1, OP_SUB, 8'hA2, 4'b0010, 4'd6, 1'b0, 1'b0, 4'd5);
        drive(1'b1, OP_XOR, 8'hA3, 4'b1001, 4'd7, 1'b0, 1'b0, 4'd6);
        check("t3_full", {31'd0, in_ready}, 32'd0);
        idle(4, 1'b1);

        // Push while the head retires; shift entry keeps flags_pend high while stalled.
        drive(1'b1, OP_LSL, 8'h40, 4'b1101, 4'd9, 1'b0, 1'b0, 4'd9);
        drive(1'b0, OP_ADD, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 4'd9);
        check("t4_pend", {31'd0, flags_pend}, 32'd1);
        drive(1'b1, OP_ADD, 8'h41, 4'b0000, 4'd10, 1'b1, 1'b0, 4'd10);
        drive(1'b1, OP_ILL, 8'h42, 4'b1111, 4'd11, 1'b1, 1'b0, 4'd11);
        idle(3, 1'b1);
        check("t4_pend_clear", {31'd0, flags_pend}, 32'd0);

        // Flush with two buffered entries and the register file ready.
        drive(1'b1, OP_ADD, 8'h51, 4'b1111, 4'd1, 1'b0, 1'b0, 4'd1);
        drive(1'b1, OP_LSL, 8'h52, 4'b1111, 4'd2, 1'b0, 1'b0, 4'd2);
        drive(1'b1, OP_ADD, 8'h53, 4'b1111, 4'd3, 1'b1, 1'b1, 4'd2);
        idle(1, 1'b1);
        check("t5_flush_wb", {31'd0, wb_valid}, 32'd0);
        check("t5_flush_flags", {28'd0, flags_q}, 32'h0);

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, OP_ADD, 8'h61, 4'b1010, 4'd4, 1'b0, 1'b0, 4'd4);
        drive(1'b1, OP_SUB, 8'h62, 4'b0101, 4'd5, 1'b0, 1'b0, 4'd4);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb.delete(); committed = 4'h0; run_flags = 4'h0;
        in_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;

        // Empty buffer, ready register file: same cycle with bypass, next cycle without.
        drive(1'b1, OP_ADD, 8'h7F, 4'b0000, 4'd2, 1'b1, 1'b0, 4'd2);
        idle(2, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), 8'($urandom),
                  4'($urandom), 4'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0, 4'($urandom));
        end
        idle(4, 1'b1);
        check("final_empty", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
